// File: rtl/sprite_pkg.sv
// Shared constants, channel indices and wrap-around delta helper for the sprite
// overlap engine.
package sprite_pkg;

  localparam int unsigned DEF_NUM_CHAR = 5;
  localparam int unsigned DEF_COORD_W  = 10;
  localparam int unsigned DEF_TILE     = 8;
  localparam int unsigned DEF_TPS      = 2;
  localparam int unsigned DEF_MAP_W    = 288;
  localparam int unsigned DEF_MAP_H    = 224;

  typedef enum logic [2:0] {
    PACMAN = 3'd0,
    BLINKY = 3'd1,
    PINKY  = 3'd2,
    INKY   = 3'd3,
    CLYDE  = 3'd4
  } char_idx_e;

  // Distance from sprite origin c forward to pixel p on a ring of length span.
  // Evaluated at 32 bits so the result is never truncated before the compare.
  function automatic logic [31:0] wrap_delta(input logic [31:0] p, input logic [31:0] c,
                                             input logic [31:0] span);
    return (p >= c) ? (p - c) : (p + span - c);
  endfunction

endpackage

// File: rtl/sprite_hit_calc.sv
// Stage-1 slice for one sprite channel: wrapped dx/dy, coverage test and the
// registered in-sprite offsets.
module sprite_hit_calc
  import sprite_pkg::*;
#(
  parameter int unsigned COORD_W = DEF_COORD_W,
  parameter int unsigned MAP_W   = DEF_MAP_W,
  parameter int unsigned MAP_H   = DEF_MAP_H,
  parameter int unsigned SPR     = DEF_TILE * DEF_TPS,
  parameter int unsigned SPR_W   = $clog2(SPR)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               pix_valid_i,
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  input  logic [COORD_W-1:0] cx_i,
  input  logic [COORD_W-1:0] cy_i,
  input  logic               en_i,
  output logic               hit_o,
  output logic [SPR_W-1:0]   dx_o,
  output logic [SPR_W-1:0]   dy_o
);

  logic [31:0]      dx_full;
  logic [31:0]      dy_full;
  logic             hit_d;
  logic             hit_q;
  logic [SPR_W-1:0] dx_q;
  logic [SPR_W-1:0] dy_q;

  always_comb begin
    dx_full = wrap_delta(32'(x_i), 32'(cx_i), MAP_W);
    dy_full = wrap_delta(32'(y_i), 32'(cy_i), MAP_H);
    hit_d   = en_i && (dx_full < SPR) && (dy_full < SPR);
  end

  // Offsets are only meaningful when hit_d is set, so the low bits suffice.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_q <= 1'b0;
      dx_q  <= '0;
      dy_q  <= '0;
    end else if (pix_valid_i) begin
      hit_q <= hit_d;
      dx_q  <= dx_full[SPR_W-1:0];
      dy_q  <= dy_full[SPR_W-1:0];
    end
  end

  assign hit_o = hit_q;
  assign dx_o  = dx_q;
  assign dy_o  = dy_q;

endmodule

// File: rtl/sprite_overlap_engine.sv
// Multi-sprite overlap engine: per-frame position shadows, per-channel hit slices,
// priority select, tile/pixel offsets and the Pac-Man/ghost collision flag.
module sprite_overlap_engine
  import sprite_pkg::*;
#(
  parameter int unsigned NUM_CHAR = DEF_NUM_CHAR,
  parameter int unsigned COORD_W  = DEF_COORD_W,
  parameter int unsigned TILE     = DEF_TILE,
  parameter int unsigned TPS      = DEF_TPS,
  parameter int unsigned MAP_W    = DEF_MAP_W,
  parameter int unsigned MAP_H    = DEF_MAP_H,
  localparam int unsigned SPR     = TILE * TPS,
  localparam int unsigned SPR_W   = $clog2(SPR),
  localparam int unsigned TILE_W  = $clog2(TILE),
  localparam int unsigned ID_W    = (NUM_CHAR > 1) ? $clog2(NUM_CHAR) : 1,
  localparam int unsigned PART_W  = (TPS > 1) ? $clog2(TPS * TPS) : 1,
  localparam int unsigned OFF_W   = $clog2(TILE * TILE)
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_frame_start,
  input  logic [NUM_CHAR*COORD_W-1:0] i_char_x,
  input  logic [NUM_CHAR*COORD_W-1:0] i_char_y,
  input  logic [NUM_CHAR-1:0]         i_char_en,
  input  logic                        i_pix_valid,
  input  logic [COORD_W-1:0]          i_x_cord,
  input  logic [COORD_W-1:0]          i_y_cord,
  output logic                        o_valid,
  output logic                        o_overlap,
  output logic [ID_W-1:0]             o_char_id,
  output logic [PART_W-1:0]           o_part_offset,
  output logic [OFF_W-1:0]            o_char_offset,
  output logic [NUM_CHAR-1:0]         o_hit_mask,
  output logic                        o_collide
);

  logic [NUM_CHAR*COORD_W-1:0] shadow_x_q;
  logic [NUM_CHAR*COORD_W-1:0] shadow_y_q;
  logic [NUM_CHAR-1:0]         shadow_en_q;
  logic [NUM_CHAR*COORD_W-1:0] cur_x;
  logic [NUM_CHAR*COORD_W-1:0] cur_y;
  logic [NUM_CHAR-1:0]         cur_en;

  logic                        valid1_q;
  logic [NUM_CHAR-1:0]         hit1;
  logic [SPR_W-1:0]            dx1 [NUM_CHAR];
  logic [SPR_W-1:0]            dy1 [NUM_CHAR];

  logic [ID_W-1:0]             win_id;
  logic [SPR_W-1:0]            win_dx;
  logic [SPR_W-1:0]            win_dy;
  logic                        found;
  logic [PART_W-1:0]           part_d;
  logic [OFF_W-1:0]            off_d;

  logic                        collide_contrib;
  logic                        acc_q;

  // A pixel arriving with the frame pulse must already see the new positions.
  always_comb begin
    cur_x  = i_frame_start ? i_char_x  : shadow_x_q;
    cur_y  = i_frame_start ? i_char_y  : shadow_y_q;
    cur_en = i_frame_start ? i_char_en : shadow_en_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shadow_x_q  <= '0;
      shadow_y_q  <= '0;
      shadow_en_q <= '0;
    end else if (i_frame_start) begin
      shadow_x_q  <= i_char_x;
      shadow_y_q  <= i_char_y;
      shadow_en_q <= i_char_en;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid1_q <= 1'b0;
    end else begin
      valid1_q <= i_pix_valid;
    end
  end

  for (genvar k = 0; k < NUM_CHAR; k++) begin : g_chan
    sprite_hit_calc #(
      .COORD_W (COORD_W),
      .MAP_W   (MAP_W),
      .MAP_H   (MAP_H),
      .SPR     (SPR),
      .SPR_W   (SPR_W)
    ) u_hit (
      .clk_i       (i_clk),
      .rst_ni      (i_rst_n),
      .pix_valid_i (i_pix_valid),
      .x_i         (i_x_cord),
      .y_i         (i_y_cord),
      .cx_i        (cur_x[k*COORD_W +: COORD_W]),
      .cy_i        (cur_y[k*COORD_W +: COORD_W]),
      .en_i        (cur_en[k]),
      .hit_o       (hit1[k]),
      .dx_o        (dx1[k]),
      .dy_o        (dy1[k])
    );
  end

  // Lowest-index hit wins; with no hit the offsets fall back to zero.
  always_comb begin
    found  = 1'b0;
    win_id = '0;
    win_dx = '0;
    win_dy = '0;
    for (int k = 0; k < NUM_CHAR; k++) begin
      if (hit1[k] && !found) begin
        found  = 1'b1;
        win_id = ID_W'(k);
        win_dx = dx1[k];
        win_dy = dy1[k];
      end
    end
    part_d = PART_W'(((32'(win_dy) >> TILE_W) * TPS) + (32'(win_dx) >> TILE_W));
    off_d  = OFF_W'(((32'(win_dx) & (TILE - 1)) * TILE) + (32'(win_dy) & (TILE - 1)));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid       <= 1'b0;
      o_overlap     <= 1'b0;
      o_char_id     <= '0;
      o_part_offset <= '0;
      o_char_offset <= '0;
      o_hit_mask    <= '0;
    end else begin
      o_valid <= valid1_q;
      if (valid1_q) begin
        o_overlap     <= |hit1;
        o_char_id     <= win_id;
        o_part_offset <= part_d;
        o_char_offset <= off_d;
        o_hit_mask    <= hit1;
      end
    end
  end

  assign collide_contrib = o_valid && o_hit_mask[PACMAN] && (|(o_hit_mask & ~NUM_CHAR'(1)));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_q     <= 1'b0;
      o_collide <= 1'b0;
    end else if (i_frame_start) begin
      o_collide <= acc_q | collide_contrib;
      acc_q     <= 1'b0;
    end else if (collide_contrib) begin
      acc_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sprite_overlap_engine.sv
// Scoreboard bench for sprite_overlap_engine: expectations are queued at drive time
// and retired by a monitor when o_valid appears.
module tb_sprite_overlap_engine;

  localparam int NC = 5;
  localparam int CW = 10;
  localparam int MW = 288;
  localparam int MH = 224;

  logic             clk = 1'b0;
  logic             i_rst_n = 1'b1;
  logic             i_frame_start = 1'b0;
  logic [NC*CW-1:0] i_char_x = '0;
  logic [NC*CW-1:0] i_char_y = '0;
  logic [NC-1:0]    i_char_en = '0;
  logic             i_pix_valid = 1'b0;
  logic [CW-1:0]    i_x_cord = '0;
  logic [CW-1:0]    i_y_cord = '0;
  logic             o_valid;
  logic             o_overlap;
  logic [2:0]       o_char_id;
  logic [1:0]       o_part_offset;
  logic [5:0]       o_char_offset;
  logic [NC-1:0]    o_hit_mask;
  logic             o_collide;

  sprite_overlap_engine dut (
    .i_clk         (clk),
    .i_rst_n       (i_rst_n),
    .i_frame_start (i_frame_start),
    .i_char_x      (i_char_x),
    .i_char_y      (i_char_y),
    .i_char_en     (i_char_en),
    .i_pix_valid   (i_pix_valid),
    .i_x_cord      (i_x_cord),
    .i_y_cord      (i_y_cord),
    .o_valid       (o_valid),
    .o_overlap     (o_overlap),
    .o_char_id     (o_char_id),
    .o_part_offset (o_part_offset),
    .o_char_offset (o_char_offset),
    .o_hit_mask    (o_hit_mask),
    .o_collide     (o_collide)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          ov;
    logic [2:0]    id;
    logic [1:0]    part;
    logic [5:0]    off;
    logic [NC-1:0] mask;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   idle_run = 100;
  int   px[NC], py[NC];
  bit   pen[NC];
  int   mx[NC], my[NC];
  bit   men[NC];
  bit   acc_m = 1'b0;

  always @(posedge clk) cyc++;

  // Blanking rule: a frame pulse needs at least two idle cycles before it.
  always @(posedge clk) begin
    if (i_rst_n && i_frame_start) begin
      checks++;
      if (idle_run < 2) begin
        errors++;
        $display("FAIL protocol: frame_start after %0d idle cycles, required >= 2", idle_run);
      end
    end
    idle_run = i_pix_valid ? 0 : idle_run + 1;
  end

  always @(negedge clk) begin
    if (o_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: o_valid=1 at cycle %0d, required no result", cyc);
      end else begin
        mon_e = sb.pop_front();
        if (o_overlap !== mon_e.ov || o_char_id !== mon_e.id || o_part_offset !== mon_e.part ||
            o_char_offset !== mon_e.off || o_hit_mask !== mon_e.mask || cyc != mon_e.cyc + 2) begin
          errors++;
          $display("FAIL pixel: got ov=%0b id=%0d part=%0d off=%0d mask=%b lat=%0d, required ov=%0b id=%0d part=%0d off=%0d mask=%b lat=2",
                   o_overlap, o_char_id, o_part_offset, o_char_offset, o_hit_mask,
                   cyc - mon_e.cyc, mon_e.ov, mon_e.id, mon_e.part, mon_e.off, mon_e.mask);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_spr(input int k, input int x, input int y, input bit en);
    px[k] = x;
    py[k] = y;
    pen[k] = en;
    i_char_x[k*CW +: CW] = CW'(x);
    i_char_y[k*CW +: CW] = CW'(y);
    i_char_en[k] = en;
  endtask

  function automatic exp_t model(input int x, input int y);
    exp_t e;
    int   dx, dy;
    bit   found;
    found = 1'b0;
    e.ov = 1'b0; e.id = '0; e.part = '0; e.off = '0; e.mask = '0; e.cyc = 0;
    for (int k = 0; k < NC; k++) begin
      dx = (x >= mx[k]) ? x - mx[k] : x + MW - mx[k];
      dy = (y >= my[k]) ? y - my[k] : y + MH - my[k];
      if (men[k] && dx < 16 && dy < 16) begin
        e.mask[k] = 1'b1;
        e.ov = 1'b1;
        if (!found) begin
          found = 1'b1;
          e.id = 3'(k);
          e.part = 2'((dy / 8) * 2 + dx / 8);
          e.off = 6'((dx % 8) * 8 + (dy % 8));
        end
      end
    end
    return e;
  endfunction

  task automatic push(input exp_t e_in);
    exp_t e;
    e = e_in;
    e.cyc = cyc;
    if (e.mask[0] && (|e.mask[NC-1:1])) acc_m = 1'b1;
    sb.push_back(e);
  endtask

  task automatic drive_pix(input int x, input int y);
    i_pix_valid = 1'b1;
    i_x_cord = CW'(x);
    i_y_cord = CW'(y);
  endtask

  task automatic send(input int x, input int y);
    @(negedge clk);
    i_frame_start = 1'b0;
    drive_pix(x, y);
    push(model(x, y));
  endtask

  task automatic send_exp(input int x, input int y, input bit ov, input int id, input int part,
                          input int off, input logic [NC-1:0] mask);
    exp_t e;
    @(negedge clk);
    i_frame_start = 1'b0;
    drive_pix(x, y);
    e.ov = ov; e.id = 3'(id); e.part = 2'(part); e.off = 6'(off); e.mask = mask; e.cyc = 0;
    push(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      i_pix_valid = 1'b0;
      i_frame_start = 1'b0;
    end
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 20) begin
      idle(1);
      t++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic frame(input bit with_pix, input int x, input int y);
    bit exp_coll;
    idle(2);
    @(negedge clk);
    i_frame_start = 1'b1;
    for (int k = 0; k < NC; k++) begin
      mx[k] = px[k]; my[k] = py[k]; men[k] = pen[k];
    end
    exp_coll = acc_m;
    acc_m = 1'b0;
    if (with_pix) begin
      drive_pix(x, y);
      push(model(x, y));
    end else begin
      i_pix_valid = 1'b0;
    end
    @(negedge clk);
    i_frame_start = 1'b0;
    i_pix_valid = 1'b0;
    checks++;
    if (o_collide !== exp_coll) begin
      errors++;
      $display("FAIL frame_collide: got %0b, required %0b", o_collide, exp_coll);
    end
  endtask

  task automatic test_reset();
    #2 i_rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_valid, o_overlap, o_char_id, o_part_offset, o_char_offset, o_hit_mask, o_collide} !== '0) begin
      errors++;
      $display("FAIL reset_state: got valid=%0b ov=%0b id=%0d part=%0d off=%0d mask=%b coll=%0b, required all 0",
               o_valid, o_overlap, o_char_id, o_part_offset, o_char_offset, o_hit_mask, o_collide);
    end
    i_rst_n = 1'b1;
    for (int k = 0; k < NC; k++) begin
      set_spr(k, 0, 0, 1'b0);
      mx[k] = 0; my[k] = 0; men[k] = 1'b0;
    end
    send_exp(50, 50, 0, 0, 0, 0, 5'b00000);
    drain();
  endtask

  task automatic test_single();
    set_spr(0, 100, 50, 1'b1);
    frame(1'b0, 0, 0);
    send_exp(107, 57, 1, 0, 0, 63, 5'b00001);
    send_exp(108, 58, 1, 0, 3, 0, 5'b00001);
    send_exp(116, 50, 0, 0, 0, 0, 5'b00000);
    send_exp(100, 50, 1, 0, 0, 0, 5'b00001);
    send_exp(115, 65, 1, 0, 3, 63, 5'b00001);
    drain();
  endtask

  task automatic test_priority();
    set_spr(0, 100, 50, 1'b0);
    set_spr(1, 40, 40, 1'b1);
    set_spr(3, 40, 40, 1'b1);
    frame(1'b0, 0, 0);
    send_exp(45, 42, 1, 1, 0, 42, 5'b01010);
    drain();
    set_spr(1, 40, 40, 1'b0);
    frame(1'b0, 0, 0);
    send_exp(45, 42, 1, 3, 0, 42, 5'b01000);
    drain();
  endtask

  task automatic test_wrap();
    set_spr(3, 40, 40, 1'b0);
    set_spr(2, 284, 100, 1'b1);
    frame(1'b0, 0, 0);
    send_exp(2, 103, 1, 2, 0, 51, 5'b00100);
    send_exp(12, 103, 0, 0, 0, 0, 5'b00000);
    send_exp(11, 103, 1, 2, 1, 59, 5'b00100);
    send_exp(287, 103, 1, 2, 0, 27, 5'b00100);
    drain();
    set_spr(2, 100, 220, 1'b1);
    frame(1'b0, 0, 0);
    send_exp(103, 5, 1, 2, 2, 25, 5'b00100);
    send_exp(103, 12, 0, 0, 0, 0, 5'b00000);
    send_exp(103, 223, 1, 2, 0, 27, 5'b00100);
    drain();
  endtask

  task automatic test_frame_latch();
    set_spr(2, 100, 220, 1'b0);
    set_spr(0, 100, 50, 1'b1);
    frame(1'b0, 0, 0);
    set_spr(0, 200, 50, 1'b1);
    send_exp(107, 57, 1, 0, 0, 63, 5'b00001);
    drain();
    frame(1'b1, 205, 55);
    drain();
    send_exp(107, 57, 0, 0, 0, 0, 5'b00000);
    send_exp(205, 55, 1, 0, 0, 45, 5'b00001);
    drain();
  endtask

  task automatic test_collision();
    set_spr(0, 10, 10, 1'b1);
    set_spr(4, 20, 20, 1'b1);
    frame(1'b0, 0, 0);
    send_exp(22, 22, 1, 0, 3, 36, 5'b10001);
    send_exp(12, 12, 1, 0, 0, 18, 5'b00001);
    drain();
    checks++;
    if (o_collide !== 1'b0) begin
      errors++;
      $display("FAIL collide_during_frame: got %0b, required 0", o_collide);
    end
    frame(1'b0, 0, 0);
    checks++;
    if (o_collide !== 1'b1) begin
      errors++;
      $display("FAIL collide_next_frame: got %0b, required 1", o_collide);
    end
    send_exp(12, 12, 1, 0, 0, 18, 5'b00001);
    drain();
    frame(1'b0, 0, 0);
    checks++;
    if (o_collide !== 1'b0) begin
      errors++;
      $display("FAIL collide_cleared: got %0b, required 0", o_collide);
    end
  endtask

  task automatic test_back_to_back();
    int k;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < NC; c++) begin
        set_spr(c, $urandom_range(0, MW - 1), $urandom_range(0, MH - 1), 1'($urandom_range(0, 1)));
      end
      frame(1'b0, 0, 0);
      for (int i = 0; i < 24; i++) begin
        k = $urandom_range(0, NC - 1);
        send((px[k] + $urandom_range(0, 19)) % MW, (py[k] + $urandom_range(0, 19)) % MH);
      end
      drain();
    end
    frame(1'b0, 0, 0);
  endtask

  task automatic test_reset_mid();
    for (int c = 1; c < 4; c++) set_spr(c, 0, 0, 1'b0);
    set_spr(0, 10, 10, 1'b1);
    set_spr(4, 20, 20, 1'b1);
    frame(1'b0, 0, 0);
    send(22, 22);
    drain();
    frame(1'b0, 0, 0);
    send(12, 12);
    send(22, 22);
    @(posedge clk);
    #2;
    checks++;
    if (o_valid !== 1'b1 || o_collide !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_inflight: got valid=%0b coll=%0b, required 1 1", o_valid, o_collide);
    end
    i_rst_n = 1'b0;
    i_pix_valid = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_collide !== 1'b0 || o_hit_mask !== '0 || o_overlap !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got valid=%0b coll=%0b mask=%b ov=%0b, required 0 0 00000 0",
               o_valid, o_collide, o_hit_mask, o_overlap);
    end
    sb.delete();
    acc_m = 1'b0;
    for (int c = 0; c < NC; c++) begin
      mx[c] = 0; my[c] = 0; men[c] = 1'b0;
    end
    repeat (2) @(negedge clk);
    i_rst_n = 1'b1;
    send_exp(22, 22, 0, 0, 0, 0, 5'b00000);
    send_exp(12, 12, 0, 0, 0, 0, 5'b00000);
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_wrap();
    test_frame_latch();
    test_collision();
    test_back_to_back();
    test_reset_mid();
    idle(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sprite_overlap_engine.md
Name: sprite_overlap_engine

Overview:
- Parametrised multi-sprite overlap/offset engine for the Pac-Man renderer. Generalises the single-character 16x16 overlap checker to NUM_CHAR sprites, configurable tile size and tiles per side, and tunnel wrap-around at the map edges.
- Sprite positions are latched per frame to avoid tearing. The engine is pipelined over 2 cycles, resolves priority (lowest index wins), and reports a per-frame Pac-Man/ghost collision flag.
- Sits between the pixel scan counter and the sprite ROM address generator.

Parameters:
- NUM_CHAR, 5, number of sprites; channel 0 is Pac-Man.
- COORD_W, 10, coordinate width.
- TILE, 8, tile edge in pixels; power of 2.
- TPS, 2, tiles per sprite side; sprite edge SPR = TILE*TPS.
- MAP_W, 288, map width in pixels; x wraps modulo MAP_W.
- MAP_H, 224, map height in pixels; y wraps modulo MAP_H.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset
- i_frame_start  in  1  one-cycle pulse; latch positions/enables, roll collision flag
- i_char_x  in  NUM_CHAR*COORD_W  packed sprite x; channel k at [k*COORD_W +: COORD_W]
- i_char_y  in  NUM_CHAR*COORD_W  packed sprite y
- i_char_en  in  NUM_CHAR  per-sprite enable
- i_pix_valid  in  1  pixel coordinate valid
- i_x_cord  in  COORD_W  pixel x, 0..MAP_W-1
- i_y_cord  in  COORD_W  pixel y, 0..MAP_H-1
- o_valid  out  1  result valid, 2 cycles after i_pix_valid
- o_overlap  out  1  any enabled sprite covers the pixel
- o_char_id  out  $clog2(NUM_CHAR)  winning sprite index
- o_part_offset  out  max(1,$clog2(TPS*TPS))  tile within sprite, row-major
- o_char_offset  out  $clog2(TILE*TILE)  pixel within tile
- o_hit_mask  out  NUM_CHAR  all sprites covering the pixel
- o_collide  out  1  previous frame had a pixel covered by channel 0 and any other channel

Behaviour:
- Reset (async, active-low): all outputs 0, shadow positions 0, shadow enables 0, collision accumulator 0, pipeline valids 0.
- Shadow latch:
  - On i_frame_start, shadow x/y/en load from the inputs.
  - A pixel accepted in the same cycle as i_frame_start uses the newly loaded values.
  - Inputs are ignored at all other times.
- Stage 1 (registered), per channel k:
  - dx = (x >= cx) ? x-cx : x+MAP_W-cx.
  - dy = (y >= cy) ? y-cy : y+MAP_H-cy.
  - Compute at COORD_W+1 bits; no truncation before the compare.
  - hit_k = en_k & (dx < SPR) & (dy < SPR).
  - Register hit_k, dx[log2 SPR-1:0] and dy[log2 SPR-1:0].
- Stage 2 (registered):
  - o_hit_mask = hits.
  - o_overlap = |hits.
  - o_char_id = lowest k with hit_k.
  - o_part_offset = (dy/TILE)*TPS + dx/TILE. For TPS=2 this gives 0 top-left, 1 top-right, 2 bottom-left, 3 bottom-right.
  - o_char_offset = (dx%TILE)*TILE + (dy%TILE).
  - No hit: id, part and char offset outputs are 0.
- Latency and throughput:
  - Exactly 2 cycles of latency; one pixel per cycle; no backpressure.
  - o_valid follows i_pix_valid delayed by 2.
  - While o_valid=0, data outputs hold their last value.
- Wrap-around: a sprite at cx=MAP_W-4 covers x = MAP_W-4..MAP_W-1 and 0..SPR-5. The same rule applies vertically.
- Collision accumulation:
  - The accumulator sets when a stage-2 valid pixel has hit_0 & |hits[NUM_CHAR-1:1].
  - On i_frame_start: o_collide <= accumulator | current stage-2 contribution, and the accumulator clears.
  - o_collide holds until the next i_frame_start.
- Protocol requirements:
  - i_frame_start must be preceded by ≥2 cycles with i_pix_valid=0 (blanking), so no in-flight pixels are split across frames.
  - The bench flags violations as a protocol error.
  - Coordinates ≥ MAP_W or ≥ MAP_H are unsupported; the bench never drives them.
- Reset mid-frame: pipeline flushes, o_valid drops immediately, shadows clear, so all sprites read as disabled until the next i_frame_start.

Decomposition:
- Shared package sprite_pkg holds:
  - constants for default MAP_W, MAP_H, TILE, TPS;
  - the NUM_CHAR channel index enum (PACMAN=0, BLINKY, PINKY, INKY, CLYDE);
  - a function to compute the wrapped delta.
- One natural sub-module: sprite_hit_calc, one instance per channel via generate. It holds stage-1 delta, wrap and hit logic plus its registers.
- The top level holds shadows, the priority encoder, offset formation and the collision accumulator.

Test Plan:
- Single sprite, ch0 at (100,50), en=1 → pixel (107,57): overlap=1, id=0, part=0, char_off=63. Pixel (108,58): part=3, char_off=0. Pixel (116,50): overlap=0. All results arrive exactly 2 cycles after i_pix_valid.
- Priority: ch1 and ch3 both at (40,40), pixel (45,42) → id=1, hit_mask=5'b01010. With ch1 disabled, the next frame gives id=3.
- Horizontal wrap: ch2 at (284,100), pixel (2,103) → overlap=1, dx=6, part=0, char_off=51. Pixel (12,103) → overlap=0. Repeat vertically with cy=220, pixel y=5.
- Frame latch: change i_char_x mid-frame without i_frame_start → results unchanged. Pulse i_frame_start with a same-cycle pixel → that pixel uses the new position.
- Collision: ch0 and ch4 overlap at one pixel in frame N → o_collide=0 during N, 1 after the next i_frame_start. No overlap in N+1 → o_collide=0 after the following start.
- Async reset asserted mid-stream with valids in flight → o_valid=0 and o_collide=0 immediately. After release, with no i_frame_start, pixels over former sprite positions give overlap=0.
